// File: rtl/grf_wb_pkg.sv
// Shared types and helpers for the GRF write-back arbiter.
package grf_wb_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] a3;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

  function automatic logic [REG_NUM-1:0] onehot5to32(input logic [REG_AW-1:0] a);
    onehot5to32    = '0;
    onehot5to32[a] = 1'b1;
  endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes storage and per-slot valid bits
// so the top can build the pending-register mask.
module grf_wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_entry_t             entry_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_entry_t             head_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic      [DEPTH-1:0] valid_o
);

  localparam int PW = $clog2(DEPTH);

  logic      [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic      [PW:0]      count_q;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic      [DEPTH-1:0] vld_q;
  logic                  push_ok, pop_ok;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign valid_o   = vld_q;

  // A full FIFO refuses a push even when the same cycle pops.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry_i;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the GRF write port between the WB stage (P) and the MDU queue (M).
// Optional write trace enabled by defining GRF_WB_TRACE_EN.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [31:0] p_pc,
  input  logic [4:0]  p_a3,
  input  logic [31:0] p_wd,
  output logic        p_stall,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_wd,
  output logic [31:0] m_pending_mask,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  wb_entry_t                  m_entry, head;
  wb_entry_t [FIFO_DEPTH-1:0] fifo_mem;
  logic      [FIFO_DEPTH-1:0] fifo_vld;
  logic                       fifo_full, fifo_empty;
  logic                       push, grant_m, grant_p;
  logic      [SW-1:0]         starve_q, starve_d;
  logic      [REG_NUM-1:0]    pend_mask;

  logic        grf_we_q;
  logic [4:0]  grf_a3_q;
  logic [31:0] grf_wd_q, grf_pc_q;

  assign m_entry = '{pc: m_pc, a3: m_a3, wd: m_wd};
  assign m_ready = !fifo_full;
  // Writes to $0 are acknowledged but never queued.
  assign push    = m_valid && m_ready && (m_a3 != '0);

  grf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .entry_i   (m_entry),
    .pop_i     (grant_m),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head),
    .entries_o (fifo_mem),
    .valid_o   (fifo_vld)
  );

  assign grant_m = !fifo_empty && (!p_valid || starve_q == SW'(MAX_WAIT));
  assign grant_p = p_valid && !grant_m;
  assign p_stall = p_valid && grant_m;

  always_comb begin
    starve_d = starve_q;
    if (grant_m || fifo_empty)
      starve_d = '0;
    else if (grant_p && starve_q != SW'(MAX_WAIT))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifo_vld[i]) pend_mask = pend_mask | onehot5to32(fifo_mem[i].a3);
    pend_mask[0] = 1'b0;
  end

  assign m_pending_mask = pend_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      starve_q <= starve_d;
      grf_we_q <= 1'b0;
      if (grant_m) begin
        grf_we_q <= 1'b1;
        grf_a3_q <= head.a3;
        grf_wd_q <= head.wd;
        grf_pc_q <= head.pc;
      end else if (grant_p && p_a3 != '0) begin
        grf_we_q <= 1'b1;
        grf_a3_q <= p_a3;
        grf_wd_q <= p_wd;
        grf_pc_q <= p_pc;
      end
    end
  end

  assign grf_we = grf_we_q;
  assign grf_a3 = grf_a3_q;
  assign grf_wd = grf_wd_q;
  assign grf_pc = grf_pc_q;

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (grf_we_q) $display("@%h: $%d <= %h", grf_pc_q, grf_a3_q, grf_wd_q);
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter.
module tb_grf_wb_arbiter;

  logic        clk, reset;
  logic        p_valid, p_stall, m_valid, m_ready, grf_we;
  logic [31:0] p_pc, p_wd, m_pc, m_wd, m_pending_mask, grf_wd, grf_pc;
  logic [4:0]  p_a3, m_a3, grf_a3;

  int checks = 0;
  int errors = 0;

  grf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_pc(p_pc), .p_a3(p_a3), .p_wd(p_wd), .p_stall(p_stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_a3(m_a3), .m_wd(m_wd),
    .m_pending_mask(m_pending_mask),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", grf_we); end
    checks++; if (grf_a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d expected 0", grf_a3); end
    checks++; if (grf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h expected 0", grf_wd); end
    checks++; if (grf_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", grf_pc); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_m_ready: got %b expected 1", m_ready); end
    checks++; if (m_pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h expected 0", m_pending_mask); end
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL reset_p_stall: got %b expected 0", p_stall); end
  endtask

  task automatic test_p_only();
    p_valid = 1'b1; p_a3 = 5'd8; p_wd = 32'hDEAD_BEEF; p_pc = 32'h0000_0100;
    #1;
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL p_only_stall: got %b expected 0", p_stall); end
    step();
    p_valid = 1'b0;
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL p_only_we: got %b expected 1", grf_we); end
    checks++; if (grf_a3 !== 5'd8) begin errors++; $display("FAIL p_only_a3: got %0d expected 8", grf_a3); end
    checks++; if (grf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p_only_wd: got %h expected deadbeef", grf_wd); end
    checks++; if (grf_pc !== 32'h0000_0100) begin errors++; $display("FAIL p_only_pc: got %h expected 00000100", grf_pc); end
    step();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL p_only_idle_we: got %b expected 0", grf_we); end
    checks++; if (grf_a3 !== 5'd8) begin errors++; $display("FAIL p_only_hold_a3: got %0d expected 8", grf_a3); end
  endtask

  task automatic test_m_only();
    m_valid = 1'b1; m_a3 = 5'd5; m_wd = 32'h0000_1234; m_pc = 32'h0000_0200;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL m_only_ready: got %b expected 1", m_ready); end
    step();
    m_valid = 1'b0;
    checks++; if (m_pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL m_only_mask_set: got %h expected 00000020", m_pending_mask); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL m_only_no_bypass: got %b expected 0", grf_we); end
    step();
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL m_only_we: got %b expected 1", grf_we); end
    checks++; if (grf_a3 !== 5'd5) begin errors++; $display("FAIL m_only_a3: got %0d expected 5", grf_a3); end
    checks++; if (grf_wd !== 32'h0000_1234) begin errors++; $display("FAIL m_only_wd: got %h expected 00001234", grf_wd); end
    checks++; if (grf_pc !== 32'h0000_0200) begin errors++; $display("FAIL m_only_pc: got %h expected 00000200", grf_pc); end
    checks++; if (m_pending_mask !== 32'd0) begin errors++; $display("FAIL m_only_mask_clr: got %h expected 0", m_pending_mask); end
    step();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL m_only_idle_we: got %b expected 0", grf_we); end
  endtask

  task automatic test_starvation();
    m_valid = 1'b1; m_a3 = 5'd7; m_wd = 32'h77; m_pc = 32'h0000_0300;
    step();
    m_valid = 1'b0;
    checks++; if (m_pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL starve_mask: got %h expected 00000080", m_pending_mask); end
    p_valid = 1'b1; p_wd = 32'h99; p_pc = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      p_a3 = 5'(9 + i);
      #1;
      checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL starve_p_win%0d_stall: got %b expected 0", i, p_stall); end
      step();
      checks++; if (grf_a3 !== 5'(9 + i)) begin errors++; $display("FAIL starve_p_win%0d_a3: got %0d expected %0d", i, grf_a3, 9 + i); end
    end
    p_a3 = 5'd12;
    #1;
    checks++; if (p_stall !== 1'b1) begin errors++; $display("FAIL starve_forced_stall: got %b expected 1", p_stall); end
    step();
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd7 || grf_wd !== 32'h77) begin
      errors++; $display("FAIL starve_forced_m: got we=%b a3=%0d wd=%h expected we=1 a3=7 wd=00000077", grf_we, grf_a3, grf_wd);
    end
    checks++; if (m_pending_mask !== 32'd0) begin errors++; $display("FAIL starve_mask_clr: got %h expected 0", m_pending_mask); end
    #1;
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL starve_after_stall: got %b expected 0", p_stall); end
    step();
    checks++; if (grf_a3 !== 5'd12 || grf_we !== 1'b1) begin errors++; $display("FAIL starve_p_resume: got we=%b a3=%0d expected we=1 a3=12", grf_we, grf_a3); end
    p_valid = 1'b0;
    step();
  endtask

  task automatic test_full();
    p_valid = 1'b1; p_a3 = 5'd20; p_wd = 32'h2020; p_pc = 32'h0000_0500;
    for (int k = 1; k <= 4; k++) begin
      m_valid = 1'b1; m_a3 = 5'(k); m_wd = 32'(k * 16'h1111); m_pc = 32'(32'h600 + 4 * k);
      step();
      checks++; if (grf_a3 !== 5'd20) begin errors++; $display("FAIL full_p_fill%0d: got %0d expected 20", k, grf_a3); end
    end
    checks++; if (m_pending_mask !== 32'h0000_001E) begin errors++; $display("FAIL full_mask: got %h expected 0000001e", m_pending_mask); end
    m_a3 = 5'd5; m_wd = 32'h5555;
    #1;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL full_m_ready: got %b expected 0", m_ready); end
    checks++; if (p_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", p_stall); end
    step();
    m_valid = 1'b0; p_valid = 1'b0;
    checks++; if (grf_a3 !== 5'd1 || grf_wd !== 32'h1111) begin errors++; $display("FAIL full_drain1: got a3=%0d wd=%h expected a3=1 wd=00001111", grf_a3, grf_wd); end
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'(k)) begin errors++; $display("FAIL full_drain%0d: got we=%b a3=%0d expected we=1 a3=%0d", k, grf_we, grf_a3, k); end
    end
    step();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL full_no_fifth: got %b expected 0", grf_we); end
    checks++; if (m_pending_mask !== 32'd0 || m_ready !== 1'b1) begin errors++; $display("FAIL full_drained: got mask=%h ready=%b expected mask=0 ready=1", m_pending_mask, m_ready); end
  endtask

  task automatic test_back_to_back();
    m_valid = 1'b1; m_a3 = 5'd3; m_wd = 32'h33; m_pc = 32'h0000_0700;
    step();
    m_a3 = 5'd6; m_wd = 32'h66; m_pc = 32'h0000_0704;
    step();
    m_valid = 1'b0;
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd3) begin errors++; $display("FAIL b2b_first: got we=%b a3=%0d expected we=1 a3=3", grf_we, grf_a3); end
    checks++; if (m_pending_mask !== 32'h0000_0040) begin errors++; $display("FAIL b2b_mask: got %h expected 00000040", m_pending_mask); end
    step();
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd6 || grf_wd !== 32'h66) begin errors++; $display("FAIL b2b_second: got we=%b a3=%0d wd=%h expected we=1 a3=6 wd=00000066", grf_we, grf_a3, grf_wd); end
    step();
  endtask

  task automatic test_zero_reg();
    m_valid = 1'b1; m_a3 = 5'd0; m_wd = 32'hBAD0; m_pc = 32'h0000_0800;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL zero_m_ready: got %b expected 1", m_ready); end
    step();
    m_valid = 1'b0;
    checks++; if (m_pending_mask !== 32'd0) begin errors++; $display("FAIL zero_m_mask: got %h expected 0", m_pending_mask); end
    step();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL zero_m_we: got %b expected 0", grf_we); end
    p_valid = 1'b1; p_a3 = 5'd0; p_wd = 32'hBAD1; p_pc = 32'h0000_0804;
    #1;
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL zero_p_stall: got %b expected 0", p_stall); end
    step();
    p_valid = 1'b0;
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL zero_p_we: got %b expected 0", grf_we); end
    step();
  endtask

  task automatic test_reset_mid();
    p_valid = 1'b1; p_a3 = 5'd20; p_wd = 32'h2020; p_pc = 32'h0000_0900;
    m_valid = 1'b1; m_a3 = 5'd13; m_wd = 32'h13;
    step();
    m_a3 = 5'd14; m_wd = 32'h14;
    step();
    m_valid = 1'b0; p_valid = 1'b0;
    checks++; if (m_pending_mask !== 32'h0000_6000) begin errors++; $display("FAIL rst_mid_pre_mask: got %h expected 00006000", m_pending_mask); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b expected 0", grf_we); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", m_ready); end
    checks++; if (m_pending_mask !== 32'd0) begin errors++; $display("FAIL rst_mid_mask: got %h expected 0", m_pending_mask); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_stale%0d: got %b expected 0", i, grf_we); end
    end
  endtask

  initial begin
    reset = 1'b1;
    p_valid = 1'b0; p_pc = '0; p_a3 = '0; p_wd = '0;
    m_valid = 1'b0; m_pc = '0; m_a3 = '0; m_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    test_reset();
    test_p_only();
    test_m_only();
    test_starvation();
    test_full();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
